// File: rtl/led_blink_pkg.sv
// Shared definitions for the multi-channel LED sequencer.
// Mode encodings, millisecond divider and PWM resolution.
package led_blink_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_BURST = 2'd3
    } mode_e;

    localparam int MS_DIV = 1000;
    localparam int PWM_W  = 8;

endpackage

// File: rtl/blink_tick_gen.sv
// Millisecond prescaler: one-cycle tick_ms every FREQ_CLOCK/1000 clocks.
// Counts 0..TICK_CYCLES-1; tick_ms is high while the count sits at the top.
module blink_tick_gen
    import led_blink_pkg::*;
#(
    parameter int FREQ_CLOCK = 12_000_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_ms
);

    localparam int TICK_CYCLES = FREQ_CLOCK / MS_DIV;
    localparam int CW = $clog2(TICK_CYCLES);

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap    = (cnt == CW'(TICK_CYCLES - 1));
    assign tick_ms = wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_blink_multi.sv
// N-channel LED sequencer with OFF/ON/BLINK/BURST modes per channel.
// Optional brightness control when LED_PWM_EN is defined.
module led_blink_multi
    import led_blink_pkg::*;
#(
    parameter int FREQ_CLOCK   = 12_000_000,
    parameter int N_CH         = 4,
    parameter int HP_W         = 16,
    parameter int HALF_DEFAULT = 1000,
    parameter int BURST_N      = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_we,
    input  logic [$clog2(N_CH)-1:0] cfg_ch,
    input  logic [1:0]              cfg_mode,
    input  logic [HP_W-1:0]         cfg_half,
`ifdef LED_PWM_EN
    input  logic [PWM_W-1:0]        cfg_duty,
`endif
    output logic                    tick_ms,
    output logic [N_CH-1:0]         led
);

    localparam int CHW = $clog2(N_CH);
    localparam int SW  = $clog2(4 * BURST_N);

    logic [N_CH-1:0] lit;
    logic [HP_W-1:0] half_in;

    // A zero half-period would never match cnt==half-1; clamp it to 1 ms.
    assign half_in = (cfg_half == '0) ? HP_W'(1) : cfg_half;

    blink_tick_gen #(
        .FREQ_CLOCK(FREQ_CLOCK)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .tick_ms(tick_ms)
    );

`ifdef LED_PWM_EN
    logic [PWM_W-1:0] pwm_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
        end
    end
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        mode_e           mode;
        logic [HP_W-1:0] half;
        logic [HP_W-1:0] cnt;
        logic [SW-1:0]   slot;
        logic [SW-1:0]   slot_nxt;
        logic            hit;
        logic            last;
        logic            run;
        logic            raw;

        assign hit  = cfg_we && (cfg_ch == CHW'(i));
        assign last = (cnt == half - 1'b1);
        assign run  = (mode == MODE_BLINK) || (mode == MODE_BURST);

        always_comb begin
            slot_nxt = '0;
            raw      = 1'b0;
            unique case (mode)
                MODE_OFF: raw = 1'b0;
                MODE_ON:  raw = 1'b1;
                MODE_BLINK: begin
                    slot_nxt = SW'(!slot[0]);
                    raw      = slot[0];
                end
                MODE_BURST: begin
                    if (slot != SW'(4 * BURST_N - 1)) begin
                        slot_nxt = slot + 1'b1;
                    end
                    raw = (slot < SW'(2 * BURST_N)) && slot[0];
                end
                default: raw = 1'b0;
            endcase
        end

        // A write restarts the phase and takes priority over a coincident tick.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mode <= MODE_BLINK;
                half <= HP_W'(HALF_DEFAULT);
                cnt  <= '0;
                slot <= '0;
            end else if (hit) begin
                mode <= mode_e'(cfg_mode);
                half <= half_in;
                cnt  <= '0;
                slot <= '0;
            end else if (tick_ms && run) begin
                if (last) begin
                    cnt  <= '0;
                    slot <= slot_nxt;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end

`ifdef LED_PWM_EN
        logic [PWM_W-1:0] duty;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                duty <= '1;
            end else if (hit) begin
                duty <= cfg_duty;
            end
        end

        assign lit[i] = raw && (pwm_cnt < duty);
`else
        assign lit[i] = raw;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led <= '0;
        end else begin
            led <= lit;
        end
    end

endmodule
